// File: rtl/operand_match_scheduler.sv
// operand_match_scheduler
// Pairs the nonzero positions of a weight bitmask and an activation bitmask.
// For each accepted block it emits one token per common nonzero position, in
// ascending order. Each token carries the dense position and the offsets of
// that element in the compressed W and A streams. A block with no common
// positions still produces a single token, flagged with oEmpty.
// Optional build macro: OPERAND_MATCH_STATS_EN adds the statMatchCount and
// statBlockCount counter outputs.
//
// state | meaning
// IDLE  | waiting for a block, iready=1
// EMIT  | presenting tokens for the registered block, ovalid=1

module operand_match_scheduler #(
    parameter int BITMASK_WIDTH = 8,
    parameter int IDX_WIDTH     = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ivalid,
    output logic                     iready,
    input  logic [BITMASK_WIDTH-1:0] bitmaskW,
    input  logic [BITMASK_WIDTH-1:0] bitmaskA,
    input  logic                     iTileLast,
    output logic                     ovalid,
    input  logic                     oready,
    output logic [IDX_WIDTH-1:0]     oPos,
    output logic [IDX_WIDTH-1:0]     oWIdx,
    output logic [IDX_WIDTH-1:0]     oAIdx,
    output logic                     oBlockLast,
    output logic                     oEmpty,
    output logic                     oTileLast
`ifdef OPERAND_MATCH_STATS_EN
    ,
    output logic [31:0]              statMatchCount,
    output logic [31:0]              statBlockCount
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                   state;
    logic [BITMASK_WIDTH-1:0] reg_w;
    logic [BITMASK_WIDTH-1:0] reg_a;
    logic                     reg_tile;
    logic [BITMASK_WIDTH-1:0] pending;

    logic [BITMASK_WIDTH-1:0] low_bit;
    logic [BITMASK_WIDTH-1:0] below_mask;
    logic [IDX_WIDTH-1:0]     pos_c;
    logic [IDX_WIDTH-1:0]     widx_c;
    logic [IDX_WIDTH-1:0]     aidx_c;
    logic                     last_c;
    logic                     empty_c;
    logic                     active;
    logic                     accept;

    // Token fields come from the lowest pending bit. The mask of lower
    // positions is forced to zero on an empty block, which keeps both
    // popcounts below BITMASK_WIDTH so they fit in IDX_WIDTH bits.
    always_comb begin
        low_bit    = pending & (~pending + 1'b1);
        below_mask = (pending == '0) ? '0 : (low_bit - 1'b1);
        empty_c    = (pending == '0);
        last_c     = ((pending & (pending - 1'b1)) == '0);
        pos_c      = '0;
        widx_c     = '0;
        aidx_c     = '0;
        for (int i = BITMASK_WIDTH - 1; i >= 0; i--) begin
            if (low_bit[i]) pos_c = i[IDX_WIDTH-1:0];
        end
        for (int i = 0; i < BITMASK_WIDTH; i++) begin
            if (below_mask[i] && reg_w[i]) widx_c = widx_c + 1'b1;
            if (below_mask[i] && reg_a[i]) aidx_c = aidx_c + 1'b1;
        end
    end

    // Output qualification. Outputs read zero outside EMIT and while reset is high.
    always_comb begin
        active     = (state == EMIT) && !reset;
        ovalid     = active;
        oPos       = active ? pos_c  : '0;
        oWIdx      = active ? widx_c : '0;
        oAIdx      = active ? aidx_c : '0;
        oBlockLast = active && last_c;
        oEmpty     = active && empty_c;
        oTileLast  = active && last_c && reg_tile;
        accept     = active && oready;
        iready     = !reset && ((state == IDLE) || (last_c && accept));
    end

    // Block load and per-token retirement of the pending match vector.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            reg_w    <= '0;
            reg_a    <= '0;
            reg_tile <= 1'b0;
            pending  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ivalid) begin
                        reg_w    <= bitmaskW;
                        reg_a    <= bitmaskA;
                        reg_tile <= iTileLast;
                        pending  <= bitmaskW & bitmaskA;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (oready) begin
                        if (last_c) begin
                            if (ivalid) begin
                                reg_w    <= bitmaskW;
                                reg_a    <= bitmaskA;
                                reg_tile <= iTileLast;
                                pending  <= bitmaskW & bitmaskA;
                            end else begin
                                pending  <= '0;
                                state    <= IDLE;
                            end
                        end else begin
                            pending <= pending & ~low_bit;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OPERAND_MATCH_STATS_EN
    // Counters for accepted real matches and for completed blocks.
    always_ff @(posedge clock) begin
        if (reset) begin
            statMatchCount <= '0;
            statBlockCount <= '0;
        end else if (accept) begin
            if (!empty_c) statMatchCount <= statMatchCount + 32'd1;
            if (last_c)   statBlockCount <= statBlockCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_match_scheduler.sv
// Directed testbench for operand_match_scheduler.
module tb_operand_match_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       ivalid;
    logic       iready;
    logic [7:0] bitmaskW;
    logic [7:0] bitmaskA;
    logic       iTileLast;
    logic       ovalid;
    logic       oready;
    logic [2:0] oPos;
    logic [2:0] oWIdx;
    logic [2:0] oAIdx;
    logic       oBlockLast;
    logic       oEmpty;
    logic       oTileLast;
`ifdef OPERAND_MATCH_STATS_EN
    logic [31:0] statMatchCount;
    logic [31:0] statBlockCount;
`endif

    int checks = 0;
    int errors = 0;

    logic [12:0] tok;
    logic [12:0] exp_tok;
    logic [12:0] held;

    always #5 clock = ~clock;

    assign tok = {ovalid, oPos, oWIdx, oAIdx, oBlockLast, oEmpty, oTileLast};

    operand_match_scheduler #(.BITMASK_WIDTH(8), .IDX_WIDTH(3)) dut (
        .clock(clock), .reset(reset), .ivalid(ivalid), .iready(iready),
        .bitmaskW(bitmaskW), .bitmaskA(bitmaskA), .iTileLast(iTileLast),
        .ovalid(ovalid), .oready(oready), .oPos(oPos), .oWIdx(oWIdx),
        .oAIdx(oAIdx), .oBlockLast(oBlockLast), .oEmpty(oEmpty),
        .oTileLast(oTileLast)
`ifdef OPERAND_MATCH_STATS_EN
        , .statMatchCount(statMatchCount), .statBlockCount(statBlockCount)
`endif
    );

    function automatic logic [12:0] mk(input logic v, input logic [2:0] p,
                                       input logic [2:0] w, input logic [2:0] a,
                                       input logic bl, input logic e, input logic t);
        return {v, p, w, a, bl, e, t};
    endfunction

    // advance one full cycle; inputs change and outputs are sampled at negedge+1
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ivalid = 1'b0; oready = 1'b1;
        bitmaskW = '0; bitmaskA = '0; iTileLast = 1'b0;
        step(); step();
        checks++;
        if (tok !== 13'd0) begin
            errors++; $display("FAIL reset_tok got %h exp %h", tok, 13'd0);
        end
        checks++;
        if (iready !== 1'b0) begin
            errors++; $display("FAIL reset_iready got %b exp 0", iready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (iready !== 1'b1 || ovalid !== 1'b0) begin
            errors++; $display("FAIL post_reset got iready=%b ovalid=%b exp 1 0", iready, ovalid);
        end
    endtask

    task automatic test_basic();
        ivalid = 1'b1; bitmaskW = 8'b1011_0110; bitmaskA = 8'b0110_0011; iTileLast = 1'b0;
        step();
        ivalid = 1'b0;
        #1;
        exp_tok = mk(1, 3'd1, 3'd0, 3'd1, 0, 0, 0);
        checks++;
        if (tok !== exp_tok) begin
            errors++; $display("FAIL basic_tok0 got %h exp %h", tok, exp_tok);
        end
        checks++;
        if (iready !== 1'b0) begin
            errors++; $display("FAIL basic_iready0 got %b exp 0", iready);
        end
        step();
        exp_tok = mk(1, 3'd5, 3'd3, 3'd2, 1, 0, 0);
        checks++;
        if (tok !== exp_tok) begin
            errors++; $display("FAIL basic_tok1 got %h exp %h", tok, exp_tok);
        end
        checks++;
        if (iready !== 1'b1) begin
            errors++; $display("FAIL basic_iready1 got %b exp 1", iready);
        end
        step();
        checks++;
        if (ovalid !== 1'b0 || iready !== 1'b1) begin
            errors++; $display("FAIL basic_idle got ovalid=%b iready=%b exp 0 1", ovalid, iready);
        end
    endtask

    task automatic test_empty();
        ivalid = 1'b1; bitmaskW = 8'hF0; bitmaskA = 8'h0F; iTileLast = 1'b1;
        step();
        ivalid = 1'b0; iTileLast = 1'b0;
        #1;
        exp_tok = mk(1, 3'd0, 3'd0, 3'd0, 1, 1, 1);
        checks++;
        if (tok !== exp_tok) begin
            errors++; $display("FAIL empty_tok got %h exp %h", tok, exp_tok);
        end
        step();
        checks++;
        if (ovalid !== 1'b0) begin
            errors++; $display("FAIL empty_done got ovalid=%b exp 0", ovalid);
        end
    endtask

    task automatic test_back_to_back();
        ivalid = 1'b1; bitmaskW = 8'hFF; bitmaskA = 8'hFF; iTileLast = 1'b0;
        step();
        ivalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] p;
            p = i[2:0];
            if (i == 7) begin
                ivalid = 1'b1; bitmaskW = 8'h01; bitmaskA = 8'h01; iTileLast = 1'b1;
            end
            #1;
            exp_tok = mk(1, p, p, p, (i == 7), 0, 0);
            checks++;
            if (tok !== exp_tok) begin
                errors++; $display("FAIL full_tok%0d got %h exp %h", i, tok, exp_tok);
            end
            if (i == 7) begin
                checks++;
                if (iready !== 1'b1) begin
                    errors++; $display("FAIL full_iready_last got %b exp 1", iready);
                end
            end
            step();
        end
        ivalid = 1'b0; iTileLast = 1'b0;
        #1;
        exp_tok = mk(1, 3'd0, 3'd0, 3'd0, 1, 0, 1);
        checks++;
        if (tok !== exp_tok) begin
            errors++; $display("FAIL b2b_tok got %h exp %h", tok, exp_tok);
        end
        step();
        checks++;
        if (ovalid !== 1'b0) begin
            errors++; $display("FAIL b2b_done got ovalid=%b exp 0", ovalid);
        end
    endtask

    task automatic test_backpressure();
        ivalid = 1'b1; bitmaskW = 8'h81; bitmaskA = 8'h81; iTileLast = 1'b0;
        step();
        ivalid = 1'b0; oready = 1'b0;
        #1;
        held = mk(1, 3'd0, 3'd0, 3'd0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (tok !== held || iready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got %h iready=%b exp %h 0", c, tok, iready, held);
            end
            step();
        end
        oready = 1'b1;
        #1;
        checks++;
        if (tok !== held) begin
            errors++; $display("FAIL bp_release got %h exp %h", tok, held);
        end
        step();
        exp_tok = mk(1, 3'd7, 3'd1, 3'd1, 1, 0, 0);
        checks++;
        if (tok !== exp_tok) begin
            errors++; $display("FAIL bp_tok1 got %h exp %h", tok, exp_tok);
        end
        step();
        checks++;
        if (ovalid !== 1'b0) begin
            errors++; $display("FAIL bp_done got ovalid=%b exp 0", ovalid);
        end
    endtask

`ifdef OPERAND_MATCH_STATS_EN
    task automatic test_stats();
        checks++;
        if (statMatchCount !== 32'd13) begin
            errors++; $display("FAIL stat_match got %0d exp 13", statMatchCount);
        end
        checks++;
        if (statBlockCount !== 32'd5) begin
            errors++; $display("FAIL stat_block got %0d exp 5", statBlockCount);
        end
    endtask
`endif

    task automatic test_reset_mid_block();
        ivalid = 1'b1; bitmaskW = 8'hFF; bitmaskA = 8'hFF; iTileLast = 1'b0;
        step();
        ivalid = 1'b0;
        step(); step(); step();
        exp_tok = mk(1, 3'd3, 3'd3, 3'd3, 0, 0, 0);
        checks++;
        if (tok !== exp_tok) begin
            errors++; $display("FAIL mid_tok3 got %h exp %h", tok, exp_tok);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (iready !== 1'b0) begin
            errors++; $display("FAIL mid_reset_iready got %b exp 0", iready);
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (ovalid !== 1'b0 || tok !== 13'd0) begin
            errors++; $display("FAIL mid_after_reset got %h exp %h", tok, 13'd0);
        end
        checks++;
        if (iready !== 1'b1) begin
            errors++; $display("FAIL mid_iready got %b exp 1", iready);
        end
`ifdef OPERAND_MATCH_STATS_EN
        checks++;
        if (statMatchCount !== 32'd0 || statBlockCount !== 32'd0) begin
            errors++; $display("FAIL stat_reset got %0d %0d exp 0 0", statMatchCount, statBlockCount);
        end
`endif
        ivalid = 1'b1; bitmaskW = 8'h02; bitmaskA = 8'h02;
        step();
        ivalid = 1'b0;
        #1;
        exp_tok = mk(1, 3'd1, 3'd0, 3'd0, 1, 0, 0);
        checks++;
        if (tok !== exp_tok) begin
            errors++; $display("FAIL mid_new_tok got %h exp %h", tok, exp_tok);
        end
        step();
        checks++;
        if (ovalid !== 1'b0) begin
            errors++; $display("FAIL mid_done got ovalid=%b exp 0", ovalid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_back_to_back();
        test_backpressure();
`ifdef OPERAND_MATCH_STATS_EN
        test_stats();
`endif
        test_reset_mid_block();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
